// File: rtl/systolic_drain_if.sv
// Signal bundle linking the drain controller to the PE array controls and the output beat stream.
// The master modport is the controller side.
interface systolic_drain_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 pe_load_sum;
   logic                 pe_stall;
   logic [COLS*32-1:0]   pe_top_sum_in;
   logic [COLS*32-1:0]   pe_bottom_sum;
   logic                 out_valid;
   logic                 out_ready;
   logic [COLS*32-1:0]   out_data;
   logic [ROW_W-1:0]     out_row;
   logic                 out_last;

   modport master (
      input  start,
      output busy, done,
      output pe_load_sum, pe_stall, pe_top_sum_in,
      input  pe_bottom_sum,
      output out_valid,
      input  out_ready,
      output out_data, out_row, out_last
   );

   modport slave (
      output start,
      input  busy, done,
      input  pe_load_sum, pe_stall, pe_top_sum_in,
      output pe_bottom_sum,
      input  out_valid,
      output out_ready,
      input  out_data, out_row, out_last
   );
endinterface

// File: rtl/systolic_drain_ctrl.sv
// Shifts finished sums out of the bottom of an output-stationary PE array, one row per cycle,
// and streams them (row ROWS-1 first) through a small first-word-fall-through buffer.
module systolic_drain_ctrl #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   systolic_drain_if.master  io_drain
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SHF_W = $clog2(ROWS + 1);
   localparam int DW    = COLS * 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_FLUSH
   } state_t;

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic               r_load_sum;
   logic               r_stall;
   logic [SHF_W-1:0]   r_shift_cnt;

   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [DW-1:0]      r_mem_data [FIFO_DEPTH];
   logic [ROW_W-1:0]   r_mem_row  [FIFO_DEPTH];

   logic               w_push;
   logic               w_pop;
   logic               w_valid;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [SHF_W-1:0]   w_shift_nxt;
   logic [ROW_W-1:0]   w_push_row;
   logic [PTR_W-1:0]   w_wr_ptr_inc;
   logic [PTR_W-1:0]   w_rd_ptr_inc;
   logic [ROW_W-1:0]   w_head_row;

   // A cycle with load_sum high is exactly a cycle that captures the bottom row.
   assign w_push     = r_load_sum;
   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid && io_drain.out_ready;
   assign w_head_row = r_mem_row[r_rd_ptr];

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      w_count_nxt  = r_count;
      w_shift_nxt  = r_shift_cnt;
      w_wr_ptr_inc = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      w_rd_ptr_inc = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      w_push_row   = ROW_W'(ROWS - 1 - int'(r_shift_cnt));
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
      if (w_push) begin
         w_shift_nxt = r_shift_cnt + SHF_W'(1);
      end
   end

   // Array controls are registered, so they are decided one cycle ahead from the
   // occupancy the buffer will hold next cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every register sees
   // the pre-edge value of every other register regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_load_sum  <= 1'b0;
         r_stall     <= 1'b0;
         r_shift_cnt <= '0;
      end else begin
         r_done     <= 1'b0;
         r_load_sum <= 1'b0;
         r_stall    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_drain.start) begin
                  r_state     <= S_DRAIN;
                  r_busy      <= 1'b1;
                  r_shift_cnt <= '0;
                  r_load_sum  <= 1'b1;
               end
            end
            S_DRAIN: begin
               r_shift_cnt <= w_shift_nxt;
               if (w_shift_nxt == SHF_W'(ROWS)) begin
                  r_state <= S_FLUSH;
               end else if (w_count_nxt < CNT_W'(FIFO_DEPTH)) begin
                  r_load_sum <= 1'b1;
               end else begin
                  r_stall <= 1'b1;
               end
            end
            S_FLUSH: begin
               if (w_pop && (w_head_row == '0)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (w_push) begin
            r_wr_ptr <= w_wr_ptr_inc;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
      end
   end

   // NOTE: buffer storage has no reset; r_count alone says which entries are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= io_drain.pe_bottom_sum;
         r_mem_row[r_wr_ptr]  <= w_push_row;
      end
   end

   assign io_drain.busy          = r_busy;
   assign io_drain.done          = r_done;
   assign io_drain.pe_load_sum   = r_load_sum;
   assign io_drain.pe_stall      = r_stall;
   assign io_drain.pe_top_sum_in = '0;
   assign io_drain.out_valid     = w_valid;
   assign io_drain.out_data      = w_valid ? r_mem_data[r_rd_ptr] : '0;
   assign io_drain.out_row       = w_valid ? w_head_row : '0;
   assign io_drain.out_last      = w_valid && (w_head_row == '0);
endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Bench for systolic_drain_ctrl: models a 4x4 PE array column chain and checks the drain
// sequence, stream handshake and array clearing cycle by cycle.
module tb_systolic_drain_ctrl;
   localparam int ROWS       = 4;
   localparam int COLS       = 4;
   localparam int FIFO_DEPTH = 2;
   localparam int DW         = COLS * 32;

   logic clk;
   logic reset;

   systolic_drain_if #(.ROWS(ROWS), .COLS(COLS)) drain_bus ();

   systolic_drain_ctrl #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .io_drain (drain_bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // PE array model: acc[0] is the top row, acc[ROWS-1] feeds pe_bottom_sum.
   logic [31:0] acc      [ROWS][COLS];
   logic [31:0] load_val [ROWS][COLS];
   logic        load_req;

   always @(posedge clk) begin
      if (load_req) begin
         acc <= load_val;
      end else if (drain_bus.pe_load_sum) begin
         for (int r = ROWS - 1; r > 0; r--)
            for (int c = 0; c < COLS; c++) acc[r][c] <= acc[r-1][c];
         for (int c = 0; c < COLS; c++) acc[0][c] <= drain_bus.pe_top_sum_in[c*32 +: 32];
      end
   end

   always_comb begin
      drain_bus.pe_bottom_sum = '0;
      for (int c = 0; c < COLS; c++) drain_bus.pe_bottom_sum[c*32 +: 32] = acc[ROWS-1][c];
   end

   // Stream monitor, sampled on the falling edge.
   logic [DW-1:0] beat_q [$];
   int            row_q  [$];
   int            n_hs   = 0;
   int            n_done = 0;
   logic          prev_stalled = 1'b0;
   logic [DW-1:0] prev_data;
   logic [1:0]    prev_row;

   always @(negedge clk) begin
      check("load_sum/stall exclusive", DW'(drain_bus.pe_load_sum && drain_bus.pe_stall), '0);
      if (prev_stalled) begin
         check("stall hold valid", DW'(drain_bus.out_valid), DW'(1));
         check("stall hold data", drain_bus.out_data, prev_data);
         check("stall hold row", DW'(drain_bus.out_row), DW'(prev_row));
      end
      prev_stalled = drain_bus.out_valid && !drain_bus.out_ready && !reset;
      prev_data    = drain_bus.out_data;
      prev_row     = drain_bus.out_row;
      if (drain_bus.out_valid && drain_bus.out_ready && !reset) begin
         n_hs++;
         beat_q.push_back(drain_bus.out_data);
         row_q.push_back(int'(drain_bus.out_row));
      end
      if (drain_bus.done) n_done++;
   end

   typedef struct {
      logic preload, start, ready;
      logic load, stall, valid;
      int   row;
      logic last, done, busy;
   } vec_t;

   vec_t vecs    [$];
   int   seg_end [$];

   function automatic vec_t mk(input logic pl, st, rd, ld, sl, vl, input int row,
                               input logic la, dn, bz);
      vec_t v;
      v.preload = pl; v.start = st; v.ready = rd;
      v.load = ld; v.stall = sl; v.valid = vl; v.row = row;
      v.last = la; v.done = dn; v.busy = bz;
      return v;
   endfunction

   // Free-flowing drain; with restart, start is re-pulsed during DRAIN and FLUSH.
   task automatic add_ramp_drain(input logic restart);
      vecs.push_back(mk(1, 1, 1,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1,  1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, restart, 1,  1, 0, 1, 3, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  1, 0, 1, 2, 0, 0, 1));
      vecs.push_back(mk(0, restart, 1,  1, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk(0, restart, 1,  0, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      seg_end.push_back(vecs.size());
   endtask

   task automatic set_ramp();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) load_val[r][c] = 32'(100 * r + c);
   endtask

   function automatic logic [7:0] status_now();
      return {drain_bus.pe_load_sum, drain_bus.pe_stall, drain_bus.out_valid,
              drain_bus.out_last, drain_bus.done, drain_bus.busy,
              drain_bus.out_valid ? drain_bus.out_row : 2'b00};
   endfunction

   function automatic int array_nonzero();
      int n = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) if (acc[r][c] != 32'd0) n++;
      return n;
   endfunction

   task automatic run_segment(input int seg);
      int first, last_idx, hs0, done0;
      logic [7:0] exp_st;
      logic [DW-1:0] exp_data;
      vec_t v;
      first    = (seg == 0) ? 0 : seg_end[seg-1];
      last_idx = seg_end[seg] - 1;
      hs0      = n_hs;
      done0    = n_done;
      set_ramp();
      for (int i = first; i <= last_idx; i++) begin
         v = vecs[i];
         @(posedge clk); #1;
         drain_bus.start     = v.start;
         drain_bus.out_ready = v.ready;
         load_req            = v.preload;
         @(negedge clk);
         exp_st = {v.load, v.stall, v.valid, v.last, v.done, v.busy, v.valid ? 2'(v.row) : 2'b00};
         check($sformatf("seg%0d cyc%0d status", seg, i - first), DW'(status_now()), DW'(exp_st));
         if (v.valid) begin
            for (int c = 0; c < COLS; c++) exp_data[c*32 +: 32] = 32'(100 * v.row + c);
            check($sformatf("seg%0d cyc%0d data", seg, i - first), drain_bus.out_data, exp_data);
         end
      end
      check($sformatf("seg%0d beat count", seg), DW'(n_hs - hs0), DW'(ROWS));
      check($sformatf("seg%0d done count", seg), DW'(n_done - done0), DW'(1));
      check($sformatf("seg%0d array cleared", seg), DW'(array_nonzero()), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [31:0] special [ROWS][COLS];
      logic [DW-1:0] exp_beat;
      bit got_done;

      // S1: ramp drain; S2: back-pressure from start; S3: ready toggling; S4: start re-pulsed
      add_ramp_drain(1'b0);
      vecs.push_back(mk(1, 1, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  1, 0, 1, 3, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  0, 1, 1, 3, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  0, 1, 1, 3, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 1, 1, 3, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  1, 0, 1, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  1, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      seg_end.push_back(vecs.size());
      vecs.push_back(mk(1, 1, 1,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  1, 0, 1, 3, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  1, 0, 1, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 1, 1, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  1, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      seg_end.push_back(vecs.size());
      add_ramp_drain(1'b1);
      add_ramp_drain(1'b0);

      reset               = 1'b1;
      drain_bus.start     = 1'b0;
      drain_bus.out_ready = 1'b0;
      load_req            = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset status", DW'(status_now()), '0);
      check("reset out_data", drain_bus.out_data, '0);
      check("reset out_row", DW'(drain_bus.out_row), '0);

      for (int s = 0; s < 4; s++) run_segment(s);

      // Extreme int32 values must pass through bit-exact.
      special[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      special[2] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
      special[1] = '{32'h1234_5678, 32'h8765_4321, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
      special[0] = '{32'h8000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'h8000_0000};
      load_val = special;
      beat_q.delete();
      row_q.delete();
      @(posedge clk); #1;
      drain_bus.start = 1'b1; drain_bus.out_ready = 1'b1; load_req = 1'b1;
      @(posedge clk); #1;
      drain_bus.start = 1'b0; load_req = 1'b0;
      got_done = 1'b0;
      for (int k = 0; k < 40 && !got_done; k++) begin
         @(negedge clk);
         if (drain_bus.done) got_done = 1'b1;
      end
      check("s5 done within bound", DW'(got_done), DW'(1));
      check("s5 beat count", DW'(beat_q.size()), DW'(ROWS));
      for (int b = 0; b < ROWS && b < beat_q.size(); b++) begin
         for (int c = 0; c < COLS; c++) exp_beat[c*32 +: 32] = special[ROWS-1-b][c];
         check($sformatf("s5 beat%0d data", b), beat_q[b], exp_beat);
         check($sformatf("s5 beat%0d row", b), DW'(row_q[b]), DW'(ROWS - 1 - b));
      end

      // Reset on the second load_sum cycle aborts the drain.
      set_ramp();
      @(posedge clk); #1;
      drain_bus.start = 1'b1; drain_bus.out_ready = 1'b1; load_req = 1'b1;
      @(posedge clk); #1;
      drain_bus.start = 1'b0; load_req = 1'b0;
      check("s6 first load_sum", DW'(drain_bus.pe_load_sum), DW'(1));
      @(posedge clk); #1;
      check("s6 second load_sum", DW'(drain_bus.pe_load_sum), DW'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("s6 post-reset status", DW'(status_now()), '0);
      check("s6 post-reset out_data", drain_bus.out_data, '0);
      check("s6 post-reset out_row", DW'(drain_bus.out_row), '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("s6 quiet cyc%0d", k),
               DW'({drain_bus.out_valid, drain_bus.busy, drain_bus.pe_load_sum}), '0);
      end
      run_segment(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
